// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (a - b), LSB first, one full-adder slice.
// Define SUB_OVERFLOW_EN to add the signed-overflow output v.
module serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic         v
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic          c;
    logic [CW-1:0] cnt;
    logic          nb;
    logic          s;
    logic          cout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (cnt == LAST) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Subtraction as a + ~b + 1: the +1 enters as the initial carry.
    always_comb begin
        nb   = ~sb[0];
        s    = sa[0] ^ nb ^ c;
        cout = (sa[0] & nb) | (sa[0] & c) | (nb & c);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sa   <= '0;
            sb   <= '0;
            d    <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            bout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        cnt <= '0;
                        c   <= 1'b1;
                    end
                end
                RUN: begin
                    d   <= {s, d[N-1:1]};
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    c   <= cout;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        bout <= ~cout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SUB_OVERFLOW_EN
    // Overflow is carry into the MSB xor carry out of it, seen on the last slice.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v <= 1'b0;
        end else if (state == RUN && cnt == LAST) begin
            v <= c ^ cout;
        end
    end
`endif

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (N=8) against an arithmetic reference model.
// Compile with SUB_OVERFLOW_EN defined to also check the overflow output.
module tb_serial_subtractor;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] d;
    logic         bout;
`ifdef SUB_OVERFLOW_EN
    logic         v;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .d       (d),
        .bout    (bout)
`ifdef SUB_OVERFLOW_EN
        ,
        .v       (v)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: plain modular arithmetic and sign rules.
    function automatic logic [N-1:0] ref_d(input int unsigned x, input int unsigned y);
        int unsigned r;
        r = (x - y) % (1 << N);
        return r[N-1:0];
    endfunction

    function automatic logic ref_bout(input int unsigned x, input int unsigned y);
        return x < y;
    endfunction

    function automatic logic ref_v(input int unsigned x, input int unsigned y);
        int sx, sy, diff;
        sx = (x >= (1 << (N - 1))) ? int'(x) - (1 << N) : int'(x);
        sy = (y >= (1 << (N - 1))) ? int'(y) - (1 << N) : int'(y);
        diff = sx - sy;
        return (diff > (1 << (N - 1)) - 1) || (diff < -(1 << (N - 1)));
    endfunction

    task automatic do_op(input string tag, input int unsigned x, input int unsigned y);
        int busy_cnt;
        int cycles;
        logic [N-1:0] exp_d;
        exp_d = ref_d(x, y);
        @(negedge clk);
        a = x[N-1:0];
        b = y[N-1:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~a;
        b = ~b;
        busy_cnt = 0;
        cycles = 0;
        while (!done && cycles < 50) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(N));
        check({tag, ".d"}, 32'(d), 32'(exp_d));
        check({tag, ".bout"}, 32'(bout), 32'(ref_bout(x, y)));
`ifdef SUB_OVERFLOW_EN
        check({tag, ".v"}, 32'(v), 32'(ref_v(x, y)));
`endif
        @(negedge clk);
        check({tag, ".done_width"}, 32'(done), 32'd0);
        check({tag, ".d_hold"}, 32'(d), 32'(exp_d));
    endtask

    initial begin
        int done_cnt;
        int last_done;
        logic prev_done;
        logic [N-1:0] exp_d;

        #12;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.d", 32'(d), 32'd0);
        check("reset.bout", 32'(bout), 32'd0);
`ifdef SUB_OVERFLOW_EN
        check("reset.v", 32'(v), 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        do_op("s100_37", 100, 37);
        do_op("s5_9", 5, 9);
        do_op("s0_0", 0, 0);
        do_op("s80_01", 8'h80, 8'h01);
        do_op("s7f_ff", 8'h7F, 8'hFF);
        do_op("s3_1", 3, 1);
        do_op("sff_00", 8'hFF, 8'h00);
        do_op("s00_ff", 8'h00, 8'hFF);
        for (int i = 0; i < 20; i++) begin
            do_op("rand", $urandom_range(0, 255), $urandom_range(0, 255));
        end

        // Second start during RUN must be ignored.
        @(negedge clk);
        a = 8'd50;
        b = 8'd20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'd1;
        b = 8'd200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        exp_d = ref_d(50, 20);
        for (int i = 0; i < 25; i++) begin
            if (done) begin
                done_cnt++;
                check("ignore.d", 32'(d), 32'(exp_d));
            end
            @(negedge clk);
        end
        check("ignore.done_count", 32'(done_cnt), 32'd1);

        // Asynchronous reset mid-RUN.
        a = 8'd250;
        b = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst.busy_before", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.d", 32'(d), 32'd0);
        check("midrst.bout", 32'(bout), 32'd0);
`ifdef SUB_OVERFLOW_EN
        check("midrst.v", 32'(v), 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("midrst.no_done", 32'(done_cnt), 32'd0);
        do_op("post_rst", 200, 55);

        // Continuous start: one result every N+2 cycles.
        @(negedge clk);
        a = 8'd10;
        b = 8'd3;
        start = 1'b1;
        done_cnt = 0;
        last_done = -1;
        prev_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                check("hold.d", 32'(d), 32'd7);
                if (prev_done) check("hold.done_width", 32'd2, 32'd1);
                if (last_done >= 0) check("hold.period", 32'(i - last_done), 32'(N + 2));
                last_done = i;
            end
            prev_done = done;
        end
        start = 1'b0;
        check("hold.done_count", 32'(done_cnt), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
